// File: rtl/poly_coef_reader.sv
// Horner evaluator for an 8-term polynomial whose coefficients live in a combinational ROM.
// The module walks the ROM from the top address down, one multiply-accumulate per clock, and saturates at all-ones.
module poly_coef_reader #(
    parameter int N_TERMS = 8,
    parameter int ADDR_W  = 3,
    parameter int DW      = 8,
    parameter int ACC_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DW-1:0]     x,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [DW-1:0]     coef_data,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              ovf
);

    localparam int                PROD_W   = ACC_W + DW;
    localparam int                ALIGN_W  = ACC_W - DW - 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TERMS - 1);

    if (ADDR_W != $clog2(N_TERMS)) begin : g_addr_w_check
        $error("ADDR_W must equal clog2(N_TERMS)");
    end
    if (ALIGN_W < 1) begin : g_acc_w_check
        $error("ACC_W must be at least DW+2 to hold a Q1.7 coefficient as Q2.14");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [ACC_W-1:0]  acc, acc_nx;
    logic [DW-1:0]     x_reg, x_reg_nx;
    logic [ADDR_W-1:0] idx, idx_nx;
    logic [ADDR_W-1:0] coef_addr_nx;
    logic              busy_nx;
    logic              done_nx;
    logic [ACC_W-1:0]  result_nx;
    logic              ovf_nx;
    logic              ovf_run, ovf_run_nx;

    // One Horner step: truncate acc*x back to Q2.14, then add the aligned coefficient.
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_q;
    logic [ACC_W-1:0]  coef_q;
    logic [ACC_W:0]    step_sum;
    logic              step_sat;
    logic [ACC_W-1:0]  step_acc;

    assign prod     = PROD_W'(acc) * PROD_W'(x_reg);
    assign prod_q   = prod[PROD_W-1:DW];
    assign coef_q   = ACC_W'({coef_data, {ALIGN_W{1'b0}}});
    assign step_sum = {1'b0, prod_q} + {1'b0, coef_q};
    assign step_sat = step_sum[ACC_W];
    assign step_acc = step_sat ? {ACC_W{1'b1}} : step_sum[ACC_W-1:0];

    // NOTE: sequential state uses <= so every register samples pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        x_reg_nx     = x_reg;
        idx_nx       = idx;
        coef_addr_nx = coef_addr;
        busy_nx      = busy;
        done_nx      = 1'b0;
        result_nx    = result;
        ovf_nx       = ovf;
        ovf_run_nx   = ovf_run;

        case (state)
            IDLE: begin
                coef_addr_nx = LAST_IDX;
                if (start) begin
                    x_reg_nx   = x;
                    busy_nx    = 1'b1;
                    ovf_run_nx = 1'b0;
                    state_nx   = LOAD;
                end
            end

            LOAD: begin
                acc_nx       = coef_q;
                idx_nx       = LAST_IDX - ADDR_W'(1);
                coef_addr_nx = LAST_IDX - ADDR_W'(1);
                state_nx     = ITER;
            end

            ITER: begin
                acc_nx = step_acc;
                if (step_sat) begin
                    ovf_run_nx = 1'b1;
                end
                if (idx == '0) begin
                    // Publish on entry to DONE so result and ovf are already valid while done is high.
                    result_nx = step_acc;
                    ovf_nx    = ovf_run | step_sat;
                    done_nx   = 1'b1;
                    state_nx  = DONE;
                end else begin
                    idx_nx       = idx - ADDR_W'(1);
                    coef_addr_nx = idx - ADDR_W'(1);
                end
            end

            DONE: begin
                busy_nx      = 1'b0;
                coef_addr_nx = LAST_IDX;
                state_nx     = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            x_reg     <= '0;
            idx       <= '0;
            coef_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            ovf_run   <= 1'b0;
        end else begin
            acc       <= acc_nx;
            x_reg     <= x_reg_nx;
            idx       <= idx_nx;
            coef_addr <= coef_addr_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            result    <= result_nx;
            ovf       <= ovf_nx;
            ovf_run   <= ovf_run_nx;
        end
    end

endmodule
